// File: rtl/featuremap_accum_nch.sv
// featuremap_accum_nch: sums one sample from every channel FIFO plus the filter bias, saturates,
// applies optional ReLU and hands the pixel downstream with end-of-row/end-of-frame flags.
module featuremap_accum_nch #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS = 8,
  parameter int NUM_CH = 8,
  parameter int ACC_GUARD = 4,
  parameter logic signed [DATA_WIDTH-1:0] BIAS = '0,
  parameter int RELU_EN = 1,
  parameter int WIDTH = 56,
  parameter int HEIGHT = 56
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH*DATA_WIDTH-1:0] data_in,
  input  logic [NUM_CH-1:0]            fifo_empty,
  output logic                         rdreq,
  input  logic                         ready_in,
  output logic                         valid_out,
  output logic [DATA_WIDTH-1:0]        data_out,
  output logic                         eol,
  output logic                         eof,
  output logic                         sat,
  output logic                         busy
);
  // FRAC_BITS only documents the Q format; the sum needs no rescaling
  localparam int AW = DATA_WIDTH + ACC_GUARD + 0 * FRAC_BITS;
  localparam int CW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  localparam int XW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  localparam int YW = HEIGHT > 1 ? $clog2(HEIGHT) : 1;
  localparam logic [CW-1:0] CH_LAST = CW'(NUM_CH - 1);
  localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);
  localparam logic signed [AW-1:0] MAXV = {{(ACC_GUARD+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [AW-1:0] MINV = {{(ACC_GUARD+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
  typedef enum logic [2:0] {IDLE, FETCH, CAPTURE, ACCUM, FINISH, OUT} state_t;
  state_t                       r_state;
  logic signed [DATA_WIDTH-1:0] r_ch [NUM_CH];
  logic signed [AW-1:0]         r_acc;
  logic [CW-1:0]                r_idx;
  logic [XW-1:0]                r_col;
  logic [YW-1:0]                r_row;
  logic                         r_rdreq;
  logic                         r_valid;
  logic                         r_sat;
  logic [DATA_WIDTH-1:0]        r_dout;
  logic                         w_hi;
  logic                         w_lo;
  logic [DATA_WIDTH-1:0]        w_clamp;
  logic [DATA_WIDTH-1:0]        w_res;
  always_comb begin
    w_hi = r_acc > MAXV;
    w_lo = r_acc < MINV;
    w_clamp = w_hi ? MAXV[DATA_WIDTH-1:0] : w_lo ? MINV[DATA_WIDTH-1:0] : r_acc[DATA_WIDTH-1:0];
    w_res = (RELU_EN != 0 && w_clamp[DATA_WIDTH-1]) ? '0 : w_clamp;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      for (int i = 0; i < NUM_CH; i++) r_ch[i] <= '0;
      r_acc <= '0;
      r_idx <= '0;
      r_col <= '0;
      r_row <= '0;
      r_rdreq <= 1'b0;
      r_valid <= 1'b0;
      r_sat <= 1'b0;
      r_dout <= '0;
    end else begin
      case (r_state)
        IDLE: if (fifo_empty == '0) begin
          r_state <= FETCH;
          r_rdreq <= 1'b1;
        end
        FETCH: begin
          r_rdreq <= 1'b0;
          r_state <= CAPTURE;
        end
        CAPTURE: begin
          for (int i = 0; i < NUM_CH; i++) r_ch[i] <= data_in[i*DATA_WIDTH +: DATA_WIDTH];
          r_acc <= AW'(BIAS);
          r_idx <= '0;
          r_state <= ACCUM;
        end
        ACCUM: begin
          r_acc <= r_acc + AW'(r_ch[r_idx]);
          r_idx <= r_idx + 1'b1;
          if (r_idx == CH_LAST) r_state <= FINISH;
        end
        FINISH: begin
          r_dout <= w_res;
          r_sat <= w_hi | w_lo;
          r_valid <= 1'b1;
          r_state <= OUT;
        end
        OUT: if (ready_in) begin
          r_valid <= 1'b0;
          r_state <= IDLE;
          r_col <= (r_col == X_LAST) ? '0 : r_col + 1'b1;
          if (r_col == X_LAST) r_row <= (r_row == Y_LAST) ? '0 : r_row + 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign rdreq = r_rdreq;
  assign valid_out = r_valid;
  assign data_out = r_dout;
  assign sat = r_valid & r_sat;
  assign eol = r_valid & (r_col == X_LAST);
  assign eof = eol & (r_row == Y_LAST);
  assign busy = r_state != IDLE;
endmodule

// File: tb/tb_featuremap_accum_nch.sv
// tb_featuremap_accum_nch: two configurations driven in lockstep; expected pixels are queued by the
// stimulus and popped by a monitor on every output handshake.
module tb_featuremap_accum_nch;
  typedef struct packed {logic [15:0] d; logic s; logic l; logic f;} exp_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [127:0] data_in = '0;
  logic [7:0] fifo_empty = '1;
  logic ready_in = 1'b1;
  logic rdreq_a, valid_a, eol_a, eof_a, sat_a, busy_a;
  logic rdreq_b, valid_b, eol_b, eof_b, sat_b, busy_b;
  logic [15:0] dout_a, dout_b;
  exp_t qa[$];
  exp_t qb[$];
  int n_chk = 0;
  int n_err = 0;
  int hs_cnt = 0;
  int pix = 0;
  always #5 clk = ~clk;
  featuremap_accum_nch #(.BIAS(16'sh0080), .RELU_EN(1), .WIDTH(4), .HEIGHT(2)) dut_a (
    .clk(clk), .rst(rst), .data_in(data_in), .fifo_empty(fifo_empty), .rdreq(rdreq_a),
    .ready_in(ready_in), .valid_out(valid_a), .data_out(dout_a), .eol(eol_a), .eof(eof_a),
    .sat(sat_a), .busy(busy_a));
  featuremap_accum_nch #(.BIAS(16'sh0000), .RELU_EN(0), .WIDTH(4), .HEIGHT(2)) dut_b (
    .clk(clk), .rst(rst), .data_in(data_in), .fifo_empty(fifo_empty), .rdreq(rdreq_b),
    .ready_in(ready_in), .valid_out(valid_b), .data_out(dout_b), .eol(eol_b), .eof(eof_b),
    .sat(sat_b), .busy(busy_b));
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask
  always @(negedge clk) if (rst && ready_in) begin
    if (valid_a) begin
      hs_cnt++;
      if (qa.size() == 0) chk("unexpected_a", {dout_a, sat_a, eol_a, eof_a}, 32'hFFFFFFFF);
      else chk($sformatf("pix_a%0d", hs_cnt), {dout_a, sat_a, eol_a, eof_a}, 32'(qa.pop_front()));
    end
    if (valid_b) begin
      if (qb.size() == 0) chk("unexpected_b", {dout_b, sat_b, eol_b, eof_b}, 32'hFFFFFFFF);
      else chk($sformatf("pix_b%0d", hs_cnt), {dout_b, sat_b, eol_b, eof_b}, 32'(qb.pop_front()));
    end
  end
  task automatic pixel(input logic [127:0] d, input logic [15:0] ea, input logic sa,
                       input logic [15:0] eb, input logic sb, input int hold);
    int hs0, lat, extra;
    logic l, f;
    logic [17:0] snap;
    l = (pix % 4) == 3;
    f = (pix % 8) == 7;
    pix++;
    qa.push_back({ea, sa, l, f});
    qb.push_back({eb, sb, l, f});
    hs0 = hs_cnt;
    data_in = d;
    ready_in = hold == 0;
    fifo_empty = '0;
    for (int k = 0; k < 40 && !rdreq_a; k++) begin @(posedge clk); #1; end
    chk("rdreq_seen", rdreq_a, 1);
    fifo_empty = '1;
    lat = 0;
    extra = 0;
    while (!valid_a && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (rdreq_a) extra++;
    end
    chk("latency", lat, 11);
    chk("single_rdreq", extra, 0);
    if (hold > 0) begin
      fifo_empty = '0;
      snap = {valid_a, eol_a, dout_a};
      extra = 0;
      repeat (hold) begin
        @(posedge clk); #1;
        if ({valid_a, eol_a, dout_a} !== snap || rdreq_a) extra++;
      end
      chk("backpressure_hold", extra, 0);
      ready_in = 1'b1;
    end
    for (int k = 0; k < 40 && hs_cnt == hs0; k++) begin @(posedge clk); #1; end
    fifo_empty = '1;
    chk("handshake_count", hs_cnt - hs0, 1);
  endtask
  initial begin
    logic [127:0] mix;
    int bad;
    #12;
    chk("reset_a", {rdreq_a, valid_a, eol_a, eof_a, sat_a, busy_a, dout_a}, 0);
    chk("reset_b", {rdreq_b, valid_b, eol_b, eof_b, sat_b, busy_b, dout_b}, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    data_in = {8{16'h0100}};
    fifo_empty = 8'h20;
    bad = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (rdreq_a || busy_a) bad++;
    end
    chk("one_fifo_empty_blocks", bad, 0);
    fifo_empty = '0;
    @(posedge clk); #1;
    chk("rdreq_after_release", rdreq_a, 1);
    pixel({8{16'h0100}}, 16'h0880, 0, 16'h0800, 0, 0);
    pixel({8{16'hFF00}}, 16'h0000, 0, 16'hF800, 0, 0);
    pixel({8{16'h7000}}, 16'h7FFF, 1, 16'h7FFF, 1, 0);
    pixel({8{16'h9000}}, 16'h0000, 1, 16'h8000, 1, 0);
    for (int c = 0; c < 8; c++) mix[c*16 +: 16] = 16'(c * 16);
    pixel(mix, 16'h0240, 0, 16'h01C0, 0, 6);
    pixel({112'h0, 16'h7F7F}, 16'h7FFF, 0, 16'h7F7F, 0, 0);
    pixel({112'h0, 16'h7F80}, 16'h7FFF, 1, 16'h7F80, 0, 0);
    pixel({112'h0, 16'h8000}, 16'h0000, 0, 16'h8000, 0, 0);
    pixel({8{16'h0100}}, 16'h0880, 0, 16'h0800, 0, 0);
    data_in = {8{16'h0200}};
    fifo_empty = '0;
    for (int k = 0; k < 40 && !rdreq_a; k++) begin @(posedge clk); #1; end
    fifo_empty = '1;
    repeat (5) begin @(posedge clk); #1; end
    rst = 1'b0;
    #2;
    chk("abort_reset_a", {rdreq_a, valid_a, eol_a, eof_a, sat_a, busy_a, dout_a}, 0);
    chk("abort_reset_b", {rdreq_b, valid_b, busy_b, dout_b}, 0);
    #2;
    rst = 1'b1;
    pix = 0;
    bad = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (valid_a || valid_b || busy_a) bad++;
    end
    chk("no_aborted_result", bad, 0);
    pixel({8{16'h0010}}, 16'h0100, 0, 16'h0080, 0, 0);
    pixel({8{16'h0020}}, 16'h0180, 0, 16'h0100, 0, 0);
    pixel({8{16'hFFF0}}, 16'h0000, 0, 16'hFF80, 0, 0);
    pixel({8{16'h0001}}, 16'h0088, 0, 16'h0008, 0, 0);
    repeat (5) @(posedge clk);
    chk("queues_drained", qa.size() + qb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end
endmodule
